exu_flush_arb: RTL and testbench

EXU_FLUSH_ARB -- requirements
Module: exu_flush_arb

---
 rtl/exu_flush_arb.sv | 133 +++++++++++++
 tb/tb_exu_flush_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_flush_arb.sv
// Arbitrates branch-misprediction and exception flush requests into a single IFU flush channel.
// Optional exception source enabled by defining FLUSH_ARB_EXCP_EN.
module exu_flush_arb #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned PC_SIZE      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               brch_req,
    output logic               brch_ack,
    input  logic [PC_SIZE-1:0] brch_add_op1,
    input  logic [PC_SIZE-1:0] brch_add_op2,
    input  logic               excp_req,
    output logic               excp_ack,
    input  logic [PC_SIZE-1:0] excp_vec,
    output logic               flush_req,
    input  logic               flush_ack,
    output logic [PC_SIZE-1:0] flush_add_op1,
    output logic [PC_SIZE-1:0] flush_add_op2,
    output logic               flush_pulse,
    output logic               busy,
    output logic [15:0]        flush_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DRN_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_SIZE-1:0] op1_q, op1_d;
    logic [PC_SIZE-1:0] op2_q, op2_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               flush_req_q;
    logic               busy_q;
    logic               idle_c;
    logic               excp_sel_c;
    logic               brch_sel_c;
    logic               pulse_c;

    // Acks are gated by rst_n so they stay low while reset is asserted.
    assign idle_c = rst_n & (state_q == S_IDLE);

`ifdef FLUSH_ARB_EXCP_EN
    assign excp_sel_c = idle_c & excp_req;
`else
    logic unused_excp;
    assign unused_excp = ^{excp_req, excp_vec};
    assign excp_sel_c  = 1'b0;
`endif

    assign brch_sel_c = idle_c & brch_req & ~excp_sel_c;
    assign pulse_c    = flush_req_q & flush_ack;

    // Next-state, operand latch and drain counter
    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        drn_d   = drn_q;
        unique case (state_q)
            S_IDLE: begin
                if (excp_sel_c) begin
                    op1_d   = excp_vec;
                    op2_d   = '0;
                    state_d = S_REQ;
                end else if (brch_sel_c) begin
                    op1_d   = brch_add_op1;
                    op2_d   = brch_add_op2;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_ack) begin
                    drn_d   = DRN_W'(DRAIN_CYCLES);
                    state_d = (DRAIN_CYCLES == 0) ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                drn_d = drn_q - DRN_W'(1);
                if (drn_q <= DRN_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operands and registered channel outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            drn_q       <= '0;
            flush_req_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            drn_q       <= drn_d;
            flush_req_q <= (state_d == S_REQ);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Saturating completed-flush counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (pulse_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign brch_ack      = brch_sel_c;
    assign excp_ack      = excp_sel_c;
    assign flush_req     = flush_req_q;
    assign flush_add_op1 = op1_q;
    assign flush_add_op2 = op2_q;
    assign flush_pulse   = pulse_c;
    assign busy          = busy_q;
    assign flush_cnt     = cnt_q;

endmodule

// File: tb/tb_exu_flush_arb.sv
// Bench for exu_flush_arb: two instances (DRAIN_CYCLES=2 and 0) checked against a request/drain model.
module tb_exu_flush_arb;

`ifdef FLUSH_ARB_EXCP_EN
    localparam bit EXCP_EN = 1'b1;
`else
    localparam bit EXCP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        brch_req = 1'b0, excp_req = 1'b0, flush_ack = 1'b0;
    logic [31:0] o1 = '0, o2 = '0, vec = '0;

    logic        ba_w [2];
    logic        ea_w [2];
    logic        fr_w [2];
    logic        fp_w [2];
    logic        bz_w [2];
    logic [31:0] f1_w [2];
    logic [31:0] f2_w [2];
    logic [15:0] cn_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exu_flush_arb #(.DRAIN_CYCLES(2), .PC_SIZE(32)) u_d2 (
        .clk(clk), .rst_n(rst_n),
        .brch_req(brch_req), .brch_ack(ba_w[0]), .brch_add_op1(o1), .brch_add_op2(o2),
        .excp_req(excp_req), .excp_ack(ea_w[0]), .excp_vec(vec),
        .flush_req(fr_w[0]), .flush_ack(flush_ack),
        .flush_add_op1(f1_w[0]), .flush_add_op2(f2_w[0]),
        .flush_pulse(fp_w[0]), .busy(bz_w[0]), .flush_cnt(cn_w[0])
    );

    exu_flush_arb #(.DRAIN_CYCLES(0), .PC_SIZE(32)) u_d0 (
        .clk(clk), .rst_n(rst_n),
        .brch_req(brch_req), .brch_ack(ba_w[1]), .brch_add_op1(o1), .brch_add_op2(o2),
        .excp_req(excp_req), .excp_ack(ea_w[1]), .excp_vec(vec),
        .flush_req(fr_w[1]), .flush_ack(flush_ack),
        .flush_add_op1(f1_w[1]), .flush_add_op2(f2_w[1]),
        .flush_pulse(fp_w[1]), .busy(bz_w[1]), .flush_cnt(cn_w[1])
    );

    // Reference model: a pending flush with its target, and a count of drain cycles left
    int          m_drn_len [2] = '{2, 0};
    bit          m_pend [2];
    int          m_drain [2];
    int          m_cnt [2];
    logic [31:0] m_op1 [2];
    logic [31:0] m_op2 [2];
    bit          m_ea [2];
    bit          m_ba [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0; m_drain[i] = 0; m_cnt[i] = 0;
            m_op1[i] = '0; m_op2[i] = '0;
        end
    endtask

    // Compare both instances against the model in the low phase of the clock
    task automatic step_check();
        bit idle;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            idle    = !m_pend[i] && (m_drain[i] == 0);
            m_ea[i] = EXCP_EN && idle && excp_req;
            m_ba[i] = idle && brch_req && !(EXCP_EN && excp_req);
            chk($sformatf("brch_ack[%0d]", i), ba_w[i], m_ba[i]);
            chk($sformatf("excp_ack[%0d]", i), ea_w[i], m_ea[i]);
            chk($sformatf("flush_req[%0d]", i), fr_w[i], m_pend[i]);
            chk($sformatf("flush_pulse[%0d]", i), fp_w[i], m_pend[i] && flush_ack);
            chk($sformatf("busy[%0d]", i), bz_w[i], !idle);
            chk($sformatf("flush_cnt[%0d]", i), cn_w[i], m_cnt[i]);
            if (m_pend[i]) begin
                chk($sformatf("op1[%0d]", i), f1_w[i], m_op1[i]);
                chk($sformatf("op2[%0d]", i), f2_w[i], m_op2[i]);
            end
        end
    endtask

    task automatic step_adv();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (m_ea[i]) begin
                m_pend[i] = 1'b1; m_op1[i] = vec; m_op2[i] = '0;
            end else if (m_ba[i]) begin
                m_pend[i] = 1'b1; m_op1[i] = o1; m_op2[i] = o2;
            end else if (m_pend[i] && flush_ack) begin
                m_pend[i] = 1'b0;
                if (m_cnt[i] < 65535) m_cnt[i]++;
                m_drain[i] = m_drn_len[i];
            end else if (m_drain[i] > 0) begin
                m_drain[i]--;
            end
        end
        #1;
    endtask

    task automatic step();
        step_check();
        step_adv();
    endtask

    task automatic set_in(input logic br, input logic ex, input logic fa,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] v);
        brch_req = br; excp_req = ex; flush_ack = fa; o1 = a; o2 = b; vec = v;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst flush_req[%0d]", i), fr_w[i], 0);
            chk($sformatf("rst busy[%0d]", i), bz_w[i], 0);
            chk($sformatf("rst flush_cnt[%0d]", i), cn_w[i], 0);
            chk($sformatf("rst acks[%0d]", i), {ba_w[i], ea_w[i], fp_w[i]}, 0);
            chk($sformatf("rst op1[%0d]", i), f1_w[i], 0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        br, fa;
        logic [31:0] a, b;
        logic        e_ba, e_fr, e_fp, e_bz;
        logic [31:0] e_op1, e_op2;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [7];
    int   pcount;

    initial begin
        tbl[0] = '{1, 0, 32'h100, 32'h20, 1, 0, 0, 0, 32'h0,   32'h0,  16'd0};
        tbl[1] = '{0, 0, 32'h555, 32'h666, 0, 1, 0, 1, 32'h100, 32'h20, 16'd0};
        tbl[2] = '{1, 0, 32'h777, 32'h888, 0, 1, 0, 1, 32'h100, 32'h20, 16'd0};
        tbl[3] = '{0, 1, 32'h0,   32'h0,  0, 1, 1, 1, 32'h100, 32'h20, 16'd0};
        tbl[4] = '{0, 1, 32'h0,   32'h0,  0, 0, 0, 1, 32'h0,   32'h0,  16'd1};
        tbl[5] = '{1, 0, 32'h0,   32'h0,  0, 0, 0, 1, 32'h0,   32'h0,  16'd1};
        tbl[6] = '{0, 0, 32'h0,   32'h0,  0, 0, 0, 0, 32'h0,   32'h0,  16'd1};

        set_in(1, 1, 1, 32'h1, 32'h2, 32'h3);
        @(posedge clk); #1;
        do_reset();

        // Branch-only flush with DRAIN_CYCLES=2, fixed expectations
        for (int c = 0; c < 7; c++) begin
            set_in(tbl[c].br, 1'b0, tbl[c].fa, tbl[c].a, tbl[c].b, 32'h0);
            step_check();
            chk($sformatf("tbl%0d brch_ack", c), ba_w[0], tbl[c].e_ba);
            chk($sformatf("tbl%0d flush_req", c), fr_w[0], tbl[c].e_fr);
            chk($sformatf("tbl%0d flush_pulse", c), fp_w[0], tbl[c].e_fp);
            chk($sformatf("tbl%0d busy", c), bz_w[0], tbl[c].e_bz);
            chk($sformatf("tbl%0d flush_cnt", c), cn_w[0], tbl[c].e_cnt);
            if (tbl[c].e_fr) begin
                chk($sformatf("tbl%0d op1", c), f1_w[0], tbl[c].e_op1);
                chk($sformatf("tbl%0d op2", c), f2_w[0], tbl[c].e_op2);
            end
            step_adv();
        end

        // Simultaneous exception and branch requests
        do_reset();
        set_in(1, 1, 1, 32'h100, 32'h20, 32'h80);
        step_check();
        chk("simul excp_ack", ea_w[0], EXCP_EN);
        chk("simul brch_ack", ba_w[0], !EXCP_EN);
        step_adv();
        excp_req = 1'b0;
        step_check();
        chk("simul op1", f1_w[0], EXCP_EN ? 32'h80 : 32'h100);
        chk("simul op2", f2_w[0], EXCP_EN ? 32'h0 : 32'h20);
        step_adv();
        repeat (4) step();
        chk("simul flush_cnt", cn_w[0], 2);

        // Backpressure: operands hold and new requests are not acked
        do_reset();
        set_in(1, 0, 0, 32'hABCD0000, 32'h1234, 32'h0);
        step();
        for (int c = 0; c < 10; c++) begin
            set_in(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom, $urandom, $urandom);
            step_check();
            chk("bp op1", f1_w[0], 32'hABCD0000);
            chk("bp op2", f2_w[0], 32'h1234);
            chk("bp brch_ack", ba_w[0], 0);
            step_adv();
        end

        // Reset while a flush is pending: abandoned, no pulse afterwards
        set_in(0, 0, 0, 32'h0, 32'h0, 32'h0);
        do_reset();
        set_in(1, 0, 0, 32'h40, 32'h4, 32'h0);
        step();
        brch_req = 1'b0;
        step();
        do_reset();
        flush_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step_check();
            chk("post-rst pulse", fp_w[0], 0);
            step_adv();
        end

        // Exception alone
        do_reset();
        set_in(0, 1, 0, 32'h0, 32'h0, 32'h200);
        step_check();
        chk("excp alone ack", ea_w[0], EXCP_EN);
        step_adv();
        step_check();
        chk("excp alone flush_req", fr_w[0], EXCP_EN);
        step_adv();

        // DRAIN_CYCLES=0: back-to-back branch flushes every 2 cycles
        do_reset();
        set_in(1, 0, 1, 32'h10, 32'h1, 32'h0);
        pcount = 0;
        for (int c = 0; c < 8; c++) begin
            step_check();
            if (fp_w[1]) pcount++;
            step_adv();
        end
        chk("b2b pulses", pcount, 4);
        chk("b2b flush_cnt", cn_w[1], 4);

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            set_in($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 30,
                   $urandom_range(0, 99) < 40, $urandom, $urandom, $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
